prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader sitting directly upstream of the CPU top-level. It accepts a byte stream over a valid/ready handshake, writes it into the 32×8 unified RAM from address 0, and zero-fills any unused words. It holds the CPU in reset until the image is complete, then releases it so execution starts from PC 0 on a clean memory image.

## Interface
- `DATA_W`, default 8: RAM word / stream byte width.
- `ADDR_W`, default 5: RAM address width.
- `DEPTH`, default 32: number of RAM words; the last address is `DEPTH-1`.

- `clk` in 1: single clock, rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: load request, sampled only in IDLE or RUN.
- `in_valid` in 1: stream byte valid.
- `in_data` in `DATA_W`: stream byte.
- `in_last` in 1: marks the final byte of the image.
- `in_ready` out 1: loader can accept a byte this cycle.
- `ram_we` out 1: RAM write strobe.
- `ram_addr` out `ADDR_W`: RAM write address.
- `ram_wdata` out `DATA_W`: RAM write data.
- `cpu_reset` out 1: active-high reset to the CPU core.
- `busy` out 1: high in LOAD, DRAIN or FILL.
- `done` out 1: high in RUN.
- `overflow` out 1: sticky; the image exceeded `DEPTH` bytes.
- `checksum` out `DATA_W`: sum mod 2^`DATA_W` of all bytes written from the stream.

## Operation
- **States:** IDLE, LOAD, DRAIN, FILL, RUN.
- **Reset values:** state IDLE; `in_ready`, `ram_we`, `ram_addr`, `ram_wdata`, `busy`, `done`, `overflow`, `checksum` all 0; `cpu_reset` 1.
- **IDLE**
  - `cpu_reset` is 1.
  - On `start`: go to LOAD, clear the write pointer, `checksum` and `overflow`.
- **LOAD**
  - `in_ready` is 1 (Moore output).
  - A beat is accepted when `in_valid` and `in_ready` are both high.
  - Each accepted beat issues a registered write of `in_data` to the current pointer, adds the byte to `checksum`, and increments the pointer.
- **Leaving LOAD:**
  - Beat with `in_last` at pointer < `DEPTH-1`: go to FILL.
  - Beat with `in_last` at pointer `DEPTH-1`: go to RUN.
  - Beat without `in_last` at pointer `DEPTH-1`: set `overflow` and go to DRAIN.
- **DRAIN**
  - `in_ready` is 1.
  - Accepted beats are discarded: no write, no checksum update.
  - Beat with `in_last`: go to RUN.
- **FILL**
  - `in_ready` is 0.
  - Writes 0x00 to each remaining address, one per cycle, ascending.
  - After issuing the write to `DEPTH-1`: go to RUN.
- **RUN**
  - `done` is 1; `cpu_reset` is 0.
  - On `start`: go to LOAD and re-arm exactly as from IDLE. `cpu_reset` returns to 1 on the same edge.
- **Ignored inputs:** `start` has no effect in LOAD, DRAIN and FILL. Stream inputs are ignored whenever `in_ready` is 0.
- **Pointer:** never wraps; a write is never issued beyond `DEPTH-1`.
- **Asynchronous reset mid-operation:** all outputs take their reset values immediately and the state returns to IDLE. RAM keeps any partially written contents until the next load.

## Timing
- All outputs are registered.
- Write latency: a beat accepted at edge E drives `ram_we`, `ram_addr` and `ram_wdata` during cycle E..E+1; the RAM captures it at E+1.
- `ram_we` is high for exactly one cycle per write.
- Back-to-back beats give one write per cycle at full throughput.
- FILL produces one write per cycle with no gaps. The first fill write follows the last stream write in the very next cycle.
- `cpu_reset` falls at the edge after entering RUN, which is the same edge on which the final RAM write is captured. The CPU's first fetch is therefore at least one cycle after the last write.
- `start` in IDLE at edge S: `in_ready` goes high from S onward.

## Test plan
- **Full image:** start, then 32 consecutive bytes 0x01..0x20 with `in_last` on the 32nd → 32 writes at addresses 0..31, no fill, `checksum`=0x10, `overflow`=0, `done`=1, and `cpu_reset` low one edge after the last write is issued.
- **Short image:** bytes 0xA1, 0xB2, 0xC3 with `in_last` on 0xC3 → addresses 0..2 written, then 29 consecutive 0x00 writes to addresses 3..31, `checksum`=0x16, `done`=1.
- **Overflow:** 34 bytes 0x01..0x22 with `in_last` on the 34th → exactly 32 writes, bytes 33–34 discarded, `overflow`=1, `checksum`=0x10, `done`=1.
- **Stall tolerance:** `in_valid` toggled every other cycle on a 4-byte image → writes only on accepted beats, addresses 0..3 contiguous, then fill from address 4.
- **Reset mid-load:** `reset_n` asserted after 10 accepted bytes → `cpu_reset`=1, `ram_we`=0, `in_ready`=0 immediately. After release plus a new `start`, the reload begins again at address 0.
- **Start handling:** `start` pulsed in RUN → `cpu_reset`=1 next edge, `done`=0, reload from address 0. `start` pulsed during LOAD → no effect.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader: streams a byte image into the unified RAM from address 0,
// zero-fills the unused tail, then releases the CPU from reset.
module prog_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, FILL, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              ovf_q, ovf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rdy_q, rdy_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;

    assign accept = in_valid && rdy_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = in_data;
                    sum_d   = sum_q + in_data;
                    // Pointer parks at the last address; it never wraps.
                    if (ptr_q == LAST) begin
                        state_d = in_last ? RUN : DRAIN;
                        if (!in_last) ovf_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                        if (in_last) state_d = FILL;
                    end
                end
            end
            DRAIN: begin
                if (accept && in_last) state_d = RUN;
            end
            FILL: begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = '0;
                if (ptr_q == LAST) state_d = RUN;
                else               ptr_d   = ptr_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state. cpu_reset drops one edge after
    // RUN is entered so the final RAM write lands before the CPU's first fetch.
    always_comb begin
        rdy_d     = (state_d == LOAD) || (state_d == DRAIN);
        busy_d    = (state_d == LOAD) || (state_d == DRAIN) || (state_d == FILL);
        done_d    = (state_d == RUN);
        cpu_rst_d = !((state_q == RUN) && (state_d == RUN));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sum_q     <= '0;
            ovf_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdy_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sum_q     <= sum_d;
            ovf_q     <= ovf_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdy_q     <= rdy_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign in_ready  = rdy_q;
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign cpu_reset = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign checksum  = sum_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes are queued as beats are driven
// and compared against the write port as it fires.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       in_ready, ram_we, cpu_reset, busy, done, overflow;
    logic [4:0] ram_addr;
    logic [7:0] ram_wdata, checksum;

    int n_cmp = 0;
    int n_bad = 0;

    logic [12:0] exp_q[$];
    logic [4:0]  mptr;
    logic        mdrain;
    logic [7:0]  msum;

    prog_loader #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .cpu_reset(cpu_reset), .busy(busy),
        .done(done), .overflow(overflow), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && ram_we) begin
            if (exp_q.size() == 0) begin
                chk("spurious_we", {27'd0, ram_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", ram_addr, e[12:8]);
                chk("wr_data", ram_wdata, e[7:0]);
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mptr = '0; msum = '0; mdrain = 1'b0;
    endtask

    // Drive one beat, wait for acceptance, and model its effect on the RAM.
    task automatic send(input logic [7:0] b, input logic last, input logic with_start);
        int n;
        in_valid = 1'b1; in_data = b; in_last = last; start = with_start;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) chk("ready_timeout", 0, 1);
        if (!mdrain) begin
            exp_q.push_back({mptr, b});
            msum = msum + b;
            if (mptr == 5'd31) begin
                if (!last) mdrain = 1'b1;
            end else begin
                mptr = mptr + 1'b1;
                if (last) begin
                    for (int a = int'(mptr); a < 32; a++) exp_q.push_back({5'(a), 8'h00});
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 100) begin @(posedge clk); #1; cycles++; end
        chk("done_timeout", done, 1);
    endtask

    task automatic drain_check();
        @(posedge clk); #1; @(posedge clk); #1;
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int cyc;
        mptr = '0; msum = '0; mdrain = 1'b0;
        #12;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_busy_done", {busy, done, overflow}, 0);
        chk("rst_checksum", checksum, 0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // Full image, no fill.
        do_start();
        chk("start_in_ready", in_ready, 1);
        chk("start_busy", busy, 1);
        for (int i = 1; i <= 32; i++) send(8'(i), i == 32, 1'b0);
        chk("full_done", done, 1);
        chk("full_cpu_reset_hold", cpu_reset, 1);
        @(posedge clk); #1;
        chk("full_cpu_reset_low", cpu_reset, 0);
        chk("full_checksum", checksum, 8'h10);
        chk("full_overflow", overflow, 0);
        drain_check();

        // Short image with zero fill; fill must run gap-free.
        do_start();
        chk("restart_cpu_reset", cpu_reset, 1);
        chk("restart_done", done, 0);
        send(8'hA1, 1'b0, 1'b0);
        send(8'hB2, 1'b0, 1'b1);  // start during LOAD is ignored
        send(8'hC3, 1'b1, 1'b0);
        chk("short_in_ready_fill", in_ready, 0);
        wait_done(cyc);
        chk("short_fill_cycles", cyc, 29);
        chk("short_checksum", checksum, 8'h16);
        drain_check();

        // Overflow: bytes 33 and 34 are discarded.
        do_start();
        for (int i = 1; i <= 34; i++) send(8'(i), i == 34, 1'b0);
        chk("ovf_done", done, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_checksum", checksum, 8'h10);
        drain_check();

        // Stall tolerance: valid toggles every other cycle.
        do_start();
        chk("restart_clears_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            send(8'h50 + 8'(i), i == 3, 1'b0);
            if (i != 3) begin @(posedge clk); #1; end
        end
        wait_done(cyc);
        chk("stall_checksum", checksum, 8'h46);
        drain_check();

        // Reset mid-load after 10 accepted bytes, then reload from address 0.
        do_start();
        for (int i = 0; i < 10; i++) send(8'h30 + 8'(i), 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'hEE;
        @(negedge clk); #1;
        reset_n = 1'b0; #1;
        chk("mid_rst_cpu_reset", cpu_reset, 1);
        chk("mid_rst_ram_we", ram_we, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_checksum", checksum, 0);
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {busy, done}, 0);
        do_start();
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        wait_done(cyc);
        chk("reload_checksum", checksum, 8'h33);
        drain_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
